// File: rtl/pe_col_acc_fifo_if.sv
// Handshake bundle between the bottom PE of a column, the column accumulator FIFO
// and the writeback stage that drains it.
interface pe_col_acc_fifo_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          I_OUT_VLD;
  logic [DW-1:0] I_OUT;
  logic          I_CLR;
  logic          I_RD_RDY;
  logic          O_RD_VLD;
  logic [DW-1:0] O_RD_DATA;
  logic          O_FULL;
  logic          O_EMPTY;
  logic [CW-1:0] O_CNT;
  logic          O_OVF;
  logic          O_SAT;

  modport master (
    output I_OUT_VLD, I_OUT, I_CLR, I_RD_RDY,
    input  O_RD_VLD, O_RD_DATA, O_FULL, O_EMPTY, O_CNT, O_OVF, O_SAT
  );

  modport slave (
    input  I_OUT_VLD, I_OUT, I_CLR, I_RD_RDY,
    output O_RD_VLD, O_RD_DATA, O_FULL, O_EMPTY, O_CNT, O_OVF, O_SAT
  );
endinterface

// File: rtl/pe_col_acc_fifo.sv
// Column accumulator: sums ACC_NUM saturating Q2.13 partial sums per output word and
// queues finished words in a DEPTH-entry FIFO drained over valid/ready.
module pe_col_acc_fifo #(
  parameter int DW      = 16,
  parameter int DEPTH   = 8,
  parameter int ACC_NUM = 4
) (
  input logic              I_CLK,
  input logic              I_RST_N,
  pe_col_acc_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int KW = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(ACC_NUM - 1);
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MAX_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_acc;
  logic [KW-1:0] r_acc_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_sat;

  logic [DW:0]   w_sum;
  logic          w_sum_ovf;
  logic [DW-1:0] w_sum_sat;
  logic [DW-1:0] w_nxt;
  logic          w_first;
  logic          w_last;
  logic          w_sat_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_drop;
  logic [CW-1:0] w_cnt_next;

  // One guard bit is enough: two DW-bit signed values never overflow DW+1 bits.
  assign w_sum     = {r_acc[DW-1], r_acc} + {bus.I_OUT[DW-1], bus.I_OUT};
  assign w_sum_ovf = w_sum[DW] ^ w_sum[DW-1];
  assign w_sum_sat = w_sum_ovf ? (w_sum[DW] ? MAX_NEG : MAX_POS) : w_sum[DW-1:0];

  assign w_first   = (r_acc_cnt == '0);
  assign w_last    = (r_acc_cnt == K_LAST);
  assign w_nxt     = w_first ? bus.I_OUT : w_sum_sat;
  assign w_sat_hit = bus.I_OUT_VLD & ~w_first & w_sum_ovf;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push  = bus.I_OUT_VLD & w_last;
  assign w_pop   = ~r_empty & bus.I_RD_RDY;
  assign w_wr_en = w_push & (~r_full | w_pop);
  assign w_drop  = w_push & r_full & ~w_pop;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_wr_en && !w_pop) begin
      w_cnt_next = r_cnt + 1'b1;
    end else if (!w_wr_en && w_pop) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
    end else if (bus.I_CLR) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
    end else if (bus.I_OUT_VLD) begin
      if (w_last) begin
        r_acc_cnt <= '0;
      end else begin
        r_acc     <= w_nxt;
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_sat    <= 1'b0;
    end else if (bus.I_CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_cnt   <= w_cnt_next;
      r_full  <= (w_cnt_next == C_FULL);
      r_empty <= (w_cnt_next == '0);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_sat_hit) begin
        r_sat <= 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy flags decide what is visible.
  always_ff @(posedge I_CLK) begin
    if (w_wr_en && !bus.I_CLR) begin
      r_mem[r_wr_ptr] <= w_nxt;
    end
  end

  // Head is read combinationally so a word pushed into an empty FIFO is visible
  // right after the edge that produced it.
  assign bus.O_RD_VLD  = ~r_empty;
  assign bus.O_RD_DATA = r_mem[r_rd_ptr];
  assign bus.O_FULL    = r_full;
  assign bus.O_EMPTY   = r_empty;
  assign bus.O_CNT     = r_cnt;
  assign bus.O_OVF     = r_ovf;
  assign bus.O_SAT     = r_sat;
endmodule
